biu_prefetch_queue: RTL and testbench
=====================================

BIU_PREFETCH_QUEUE -- requirements
Module: biu_prefetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries in bytes (power of two, 2..16).
REQ-002 SHALL have parameter BOOT_ADDR, default 16'h0000, meaning the first fetch address after reset.
REQ-003 SHALL have port CORE_CLK  in  1  single clock for all state.
REQ-004 SHALL have port RST_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  in  1  discard queued and in-flight bytes and redirect fetch.
REQ-006 SHALL have port flush_addr  in  16  new fetch address, sampled when flush=1.
REQ-007 SHALL have port rom_addr  out  12  program-RAM port-A read address.
REQ-008 SHALL have port rom_data  in  8  program-RAM port-A read data, valid one cycle after rom_addr.
REQ-009 SHALL have port q_byte  out  8  head-of-queue opcode byte.
REQ-010 SHALL have port q_pc  out  16  code address of q_byte.
REQ-011 SHALL have port q_valid  out  1  queue non-empty.
REQ-012 SHALL have port q_pop  in  1  consumer takes the head byte this cycle.

Function
REQ-013 SHALL keep a 16-bit fetch_pc; rom_addr = fetch_pc[11:0], with the 12-bit address wrapping 4095->0.
REQ-014 SHALL issue a read (fetch_pc += 1 mod 2^16) when count + inflight - pop_ok < DEPTH, where pop_ok = q_pop & q_valid.
REQ-015 SHALL mark an issued read inflight for exactly one cycle and push rom_data with its pc into the queue in the following cycle.
REQ-016 SHALL ignore q_pop while q_valid=0, with no state change.
REQ-017 SHALL allow push and pop in the same cycle, including when count=DEPTH, with count unchanged.
REQ-018 SHALL never exceed DEPTH entries and never drop a returned byte except under flush.
REQ-019 SHALL, on flush, empty the queue, cancel any inflight byte, set rom_addr=flush_addr[11:0] in that same cycle, issue that read, and set fetch_pc=flush_addr+1.
REQ-020 SHALL give flush priority over a simultaneous q_pop or push; q_valid SHALL be 0 in the cycle after flush.
REQ-021 SHALL provide first-byte latency of 2 cycles after flush (q_valid=1 in cycle flush+2, q_pc=flush_addr).
REQ-022 SHALL use FSM states BOOT and RUN: reset enters BOOT; BOOT drives rom_addr=BOOT_ADDR[11:0], issues that read, and goes to RUN; RUN SHALL behave per REQ-014..REQ-020.
REQ-023 SHALL derive q_byte and q_pc from registers only, with no combinational path from rom_data.

Reset
REQ-024 SHALL, while RST_n=0, force state=BOOT, fetch_pc=BOOT_ADDR, count=0, inflight=0, q_valid=0, q_byte=8'h00, q_pc=16'h0000.
REQ-025 SHALL, on reset asserted mid-operation, immediately discard queued and inflight bytes; the first push after release SHALL be BOOT_ADDR.
REQ-026 SHALL resume fetching from BOOT_ADDR on the first CORE_CLK edge after RST_n deasserts.

Structure
REQ-027 SHALL take the FSM state encoding (BOOT, RUN) and the ROM address width constant (12) from the shared MCL51 BIU package.
REQ-028 SHALL instantiate one sub-module, biu_byte_fifo (DEPTH x 24-bit data+pc storage with count, push, pop, clear).
REQ-029 SHALL contain no memory array other than biu_byte_fifo and no second clock domain.

Verification
REQ-030 SHALL cover reset release with RAM[0..3]=02,00,30,E4 and no pop -> four entries 02/0000, 00/0001, 30/0002, E4/0003, then rom_addr frozen at 004.
REQ-031 SHALL cover q_pop held high for 8 cycles after fill -> one byte per cycle with consecutive q_pc and no bubble.
REQ-032 SHALL cover flush with flush_addr=16'h0123 while full and an inflight read is pending -> q_valid=0 next cycle, q_pc=0123 at flush+2, stale byte never seen.
REQ-033 SHALL cover fetch_pc 16'h0FFE with continuous pop -> q_pc 0FFE, 0FFF, 1000 with rom_addr 0FFE, 0FFF, 000.
REQ-034 SHALL cover RST_n pulsed low for 1 cycle mid-stream -> q_valid=0 asynchronously, refetch from BOOT_ADDR.
REQ-035 SHALL cover q_pop asserted while empty -> no underflow; count stays 0 and the next pushed byte is correct.

Source files
------------

// File: rtl/biu_prefetch_queue_pkg.sv
// Shared MCL51 BIU definitions: fetch FSM encoding and program-RAM geometry.
package biu_prefetch_queue_pkg;

    // Fetch sequencer states: BOOT issues the reset-vector read, RUN streams.
    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } biu_state_t;

    // Program-RAM port-A address width.
    localparam int ROM_AW = 12;

    // Queue entry: {pc[15:0], byte[7:0]}.
    localparam int ENTRY_W = 24;

endpackage

// File: rtl/biu_byte_fifo.sv
// Small register FIFO holding {pc, opcode byte} entries for the prefetch queue.
// Clear wins over push/pop. Push while full is accepted only with a pop.
module biu_byte_fifo
    import biu_prefetch_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_clear,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [ENTRY_W-1:0] i_data,
    output logic [ENTRY_W-1:0] o_head,
    output logic [CW-1:0]      o_count
);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_pop  = i_pop & (r_count != '0) & ~i_clear;
    assign w_do_push = i_push & ((r_count < CW'(DEPTH)) | w_do_pop) & ~i_clear;

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Entry storage; contents are only observed through a non-zero count.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/biu_prefetch_queue.sv
// MCL51 bus-interface prefetch queue: streams opcode bytes from program RAM
// (one-cycle read latency) into a DEPTH-entry queue, redirectable by flush.
// Handshake: the consumer takes the head when q_pop=1 and q_valid=1 in the
// same cycle; q_pop with q_valid=0 is ignored. Flush overrides pop and push.
module biu_prefetch_queue
    import biu_prefetch_queue_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter logic [15:0] BOOT_ADDR = 16'h0000
) (
    input  logic              CORE_CLK,
    input  logic              RST_n,
    input  logic              flush,
    input  logic [15:0]       flush_addr,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        q_byte,
    output logic [15:0]       q_pc,
    output logic              q_valid,
    input  logic              q_pop,
    output logic              o_dbg_state
);

    localparam int CW = $clog2(DEPTH + 1);

    biu_state_t         r_state;
    biu_state_t         w_state_nxt;
    logic [15:0]        r_fetch_pc;
    logic               r_inflight;
    logic [15:0]        r_inflight_pc;

    logic               w_issue;
    logic [15:0]        w_issue_pc;
    logic               w_clear;
    logic               w_push;
    logic               w_pop_ok;
    logic [CW-1:0]      w_count;
    logic [CW:0]        w_fill;
    logic [CW:0]        w_limit;
    logic [ENTRY_W-1:0] w_head;

    assign q_valid  = (w_count != '0);
    assign w_pop_ok = q_pop & q_valid;

    // count + inflight - pop_ok < DEPTH, rearranged to avoid underflow.
    assign w_fill  = {1'b0, w_count} + (CW+1)'(r_inflight);
    assign w_limit = (CW+1)'(DEPTH) + (CW+1)'(w_pop_ok);

    assign rom_addr    = w_issue_pc[ROM_AW-1:0];
    assign o_dbg_state = r_state;

    // Head outputs come straight from queue registers, zero while empty.
    assign q_byte = q_valid ? w_head[7:0]  : 8'h00;
    assign q_pc   = q_valid ? w_head[23:8] : 16'h0000;

    // Next-state and fetch decisions; flush redirects from any state.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_issue_pc  = r_fetch_pc;
        w_clear     = 1'b0;
        w_push      = 1'b0;
        if (flush) begin
            w_clear     = 1'b1;
            w_issue     = 1'b1;
            w_issue_pc  = flush_addr;
            w_state_nxt = RUN;
        end else begin
            case (r_state)
                BOOT: begin
                    w_issue     = 1'b1;
                    w_state_nxt = RUN;
                end
                RUN: begin
                    w_push  = r_inflight;
                    w_issue = (w_fill < w_limit);
                end
                default: w_state_nxt = BOOT;
            endcase
        end
    end

    // State, fetch pointer and the single outstanding-read tracker.
    always_ff @(posedge CORE_CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state       <= BOOT;
            r_fetch_pc    <= BOOT_ADDR;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 16'h0000;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_issue;
            if (w_issue) begin
                r_fetch_pc    <= w_issue_pc + 16'd1;
                r_inflight_pc <= w_issue_pc;
            end
        end
    end

    biu_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (CORE_CLK),
        .i_rst_n (RST_n),
        .i_clear (w_clear),
        .i_push  (w_push),
        .i_pop   (w_pop_ok & ~flush),
        .i_data  ({r_inflight_pc, rom_data}),
        .o_head  (w_head),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_biu_prefetch_queue.sv
// Bench for biu_prefetch_queue: cycle-by-cycle vector table plus an
// asynchronous mid-cycle reset sequence with a bounded first-byte wait.
module tb_biu_prefetch_queue;
    import biu_prefetch_queue_pkg::*;

    logic        CORE_CLK;
    logic        RST_n;
    logic        flush;
    logic [15:0] flush_addr;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  q_byte;
    logic [15:0] q_pc;
    logic        q_valid;
    logic        q_pop;
    logic        dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        rst_n;
        logic        pop;
        logic        flush;
        logic [15:0] faddr;
        logic        exp_v;
        logic [7:0]  exp_b;
        logic [15:0] exp_pc;
        logic [11:0] exp_a;
    } vec_t;

    vec_t       vecs [37];
    logic [7:0] ram  [4096];

    biu_prefetch_queue #(
        .DEPTH     (4),
        .BOOT_ADDR (16'h0000)
    ) dut (
        .CORE_CLK    (CORE_CLK),
        .RST_n       (RST_n),
        .flush       (flush),
        .flush_addr  (flush_addr),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .q_byte      (q_byte),
        .q_pc        (q_pc),
        .q_valid     (q_valid),
        .q_pop       (q_pop),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        CORE_CLK = 1'b0;
        forever #5 CORE_CLK = ~CORE_CLK;
    end

    // program RAM: registered read, data one cycle after address
    always @(posedge CORE_CLK) rom_data <= ram[rom_addr];

    function automatic vec_t mk(logic r, logic p, logic f, logic [15:0] fa,
                                logic v, logic [7:0] b, logic [15:0] pc, logic [11:0] a);
        vec_t t;
        t.rst_n = r; t.pop = p; t.flush = f; t.faddr = fa;
        t.exp_v = v; t.exp_b = b; t.exp_pc = pc; t.exp_a = a;
        return t;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        int lat;
        for (int a = 0; a < 4096; a++) ram[a] = 8'(a) + 8'h10;
        ram[0] = 8'h02; ram[1] = 8'h00; ram[2] = 8'h30; ram[3] = 8'hE4;

        RST_n = 1'b0; flush = 1'b0; flush_addr = 16'h0000; q_pop = 1'b0;

        //                rst pop fl  faddr     v  byte   pc        addr
        vecs[0]  = mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 12'h000);
        vecs[1]  = mk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 12'h000);
        // reset release, fill without pop
        vecs[2]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 12'h000);
        vecs[3]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 12'h001);
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h02, 16'h0000, 12'h002);
        vecs[5]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h02, 16'h0000, 12'h003);
        vecs[6]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h02, 16'h0000, 12'h004);
        vecs[7]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h02, 16'h0000, 12'h004);
        vecs[8]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h02, 16'h0000, 12'h004);
        // eight back-to-back pops
        vecs[9]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h02, 16'h0000, 12'h004);
        vecs[10] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h00, 16'h0001, 12'h005);
        vecs[11] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h30, 16'h0002, 12'h006);
        vecs[12] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 8'hE4, 16'h0003, 12'h007);
        vecs[13] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h14, 16'h0004, 12'h008);
        vecs[14] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h15, 16'h0005, 12'h009);
        vecs[15] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h16, 16'h0006, 12'h00A);
        vecs[16] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h17, 16'h0007, 12'h00B);
        // flush with pop and a returning read: queue+inflight at DEPTH
        vecs[17] = mk(1'b1, 1'b1, 1'b1, 16'h0123, 1'b1, 8'h18, 16'h0008, 12'h123);
        vecs[18] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 12'h124);
        vecs[19] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h33, 16'h0123, 12'h125);
        vecs[20] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h33, 16'h0123, 12'h126);
        vecs[21] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h33, 16'h0123, 12'h127);
        vecs[22] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h33, 16'h0123, 12'h127);
        vecs[23] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h34, 16'h0124, 12'h128);
        vecs[24] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h35, 16'h0125, 12'h129);
        // flush to 0FFE, pop held (first pop lands on an empty queue)
        vecs[25] = mk(1'b1, 1'b0, 1'b1, 16'h0FFE, 1'b1, 8'h36, 16'h0126, 12'hFFE);
        vecs[26] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 12'hFFF);
        vecs[27] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h0E, 16'h0FFE, 12'h000);
        vecs[28] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h0F, 16'h0FFF, 12'h001);
        vecs[29] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h02, 16'h1000, 12'h002);
        vecs[30] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h00, 16'h1001, 12'h003);
        // one-cycle reset pulse mid-stream, pops while empty after release
        vecs[31] = mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 12'h000);
        vecs[32] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 12'h000);
        vecs[33] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 16'h0000, 12'h001);
        vecs[34] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 8'h02, 16'h0000, 12'h002);
        vecs[35] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h02, 16'h0000, 12'h003);
        vecs[36] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 8'h00, 16'h0001, 12'h004);

        // driver + checker: drive on falling edge, sample 1 time unit later
        for (int i = 0; i < 37; i++) begin
            @(negedge CORE_CLK);
            RST_n      = vecs[i].rst_n;
            q_pop      = vecs[i].pop;
            flush      = vecs[i].flush;
            flush_addr = vecs[i].faddr;
            #1;
            chk("q_valid", i, 32'(q_valid), 32'(vecs[i].exp_v));
            chk("rom_addr", i, 32'(rom_addr), 32'(vecs[i].exp_a));
            if (vecs[i].exp_v || !vecs[i].rst_n) begin
                chk("q_byte", i, 32'(q_byte), 32'(vecs[i].exp_b));
                chk("q_pc", i, 32'(q_pc), 32'(vecs[i].exp_pc));
            end
            if (!vecs[i].rst_n) chk("state_boot", i, 32'(dbg_state), 32'(BOOT));
        end

        // asynchronous reset asserted mid-cycle while the queue holds bytes
        @(negedge CORE_CLK);
        q_pop = 1'b0; flush = 1'b0;
        @(posedge CORE_CLK);
        #2;
        RST_n = 1'b0;
        #1;
        chk("async_q_valid", 100, 32'(q_valid), 32'd0);
        chk("async_q_pc", 100, 32'(q_pc), 32'h0000);
        chk("async_q_byte", 100, 32'(q_byte), 32'h00);
        chk("async_rom_addr", 100, 32'(rom_addr), 32'h000);
        @(negedge CORE_CLK);
        RST_n = 1'b1;
        #1;
        chk("boot_q_valid", 101, 32'(q_valid), 32'd0);
        chk("boot_rom_addr", 101, 32'(rom_addr), 32'h000);
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge CORE_CLK);
            #1;
            if (q_valid) begin
                lat = c;
                break;
            end
        end
        chk("boot_latency", 102, 32'(lat), 32'd2);
        chk("boot_q_pc", 102, 32'(q_pc), 32'h0000);
        chk("boot_q_byte", 102, 32'(q_byte), 32'h02);
        chk("state_run", 102, 32'(dbg_state), 32'(RUN));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
